mem_fifo_drain: RTL and testbench

Downstream drain stage for `memory_core` in FIFO mode (`mode`=1). It issues `ren_in` to the core only when the core holds data and local buffer space is guaranteed. It captures each `valid_out`/`data_out` beat one cycle after the read and presents the words on a ready/valid stream to the next consumer. It also tracks core occupancy against the configured `depth` and raises sticky protocol-error flags for formal and simulation checks.

---
 rtl/mem_fifo_drain.sv | 173 +++++++++++++++++
 tb/tb_mem_fifo_drain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_drain.sv
// ---------------------------------------------------------------------------
// mem_fifo_drain
// Drain stage for memory_core running in FIFO mode. It issues reads to the
// core only while the core holds data and local buffer space is guaranteed.
// Each returned beat is captured into a small circular buffer and presented
// on a ready/valid stream. It also tracks core occupancy against the
// configured depth and keeps sticky protocol-error flags.
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   clk_en        state advances only when high
//   flush         synchronous clear at the next qualified edge
//   depth         configured core FIFO depth (static after reset, > 0)
//   wen_mon       copy of the core write strobe
//   mem_ren       core read strobe (ren_in)
//   mem_valid     core valid_out, one cycle after a read
//   mem_data      core data_out
//   out_valid     head word available
//   out_data      head word
//   out_ready     consumer accepts head word
//   occupancy     words written to the core and not yet read
//   empty / full  occupancy == 0 / occupancy == depth
//   err_flags     sticky: [0] overflow, [1] spurious valid, [2] missing valid
// ---------------------------------------------------------------------------
module mem_fifo_drain #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OCC_WIDTH  = 16,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic [OCC_WIDTH-1:0]  depth,
    input  logic                  wen_mon,
    output logic                  mem_ren,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [OCC_WIDTH-1:0]  occupancy,
    output logic                  empty,
    output logic                  full,
    output logic [2:0]            err_flags
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]   BUF_DEPTH_X = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] BUF_FULL    = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(BUF_DEPTH - 1);

    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      buf_count_q, buf_count_d;
    logic [2:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];

    logic                  pop;
    logic                  push;
    logic                  occ_full;
    logic [CNT_W:0]        buf_lookahead;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign occ_full = (occ_q == depth);
    assign pop      = clk_en & out_ready & (buf_count_q != '0);

    // Buffer entries committed once this cycle resolves: held words plus the
    // read already in flight, minus the word leaving now. pop implies
    // buf_count_q > 0, so this never underflows.
    assign buf_lookahead = {1'b0, buf_count_q}
                         + {{CNT_W{1'b0}}, inflight_q}
                         - {{CNT_W{1'b0}}, pop};

    assign mem_ren = clk_en & ~flush & (occ_q != '0) & (buf_lookahead < BUF_DEPTH_X);

    assign out_valid = (buf_count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign occupancy = occ_q;
    assign empty     = (occ_q == '0);
    assign full      = occ_full;
    assign err_flags = err_q;

    always_comb begin
        occ_d       = occ_q;
        inflight_d  = inflight_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        buf_count_d = buf_count_q;
        err_d       = err_q;
        mem_d       = mem_q;
        push        = 1'b0;

        if (clk_en) begin
            if (flush) begin
                occ_d       = '0;
                inflight_d  = 1'b0;
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                buf_count_d = '0;
                err_d       = '0;
            end else begin
                inflight_d = mem_ren;

                // Core occupancy; a write into a full core with no read is lost.
                if (wen_mon && occ_full && !mem_ren) begin
                    err_d[0] = 1'b1;
                end else if (wen_mon && !mem_ren) begin
                    occ_d = occ_q + 1'b1;
                end else if (!wen_mon && mem_ren) begin
                    occ_d = occ_q - 1'b1;
                end

                // Capture of the beat returned for last cycle's read.
                if (mem_valid && !inflight_q) begin
                    err_d[1] = 1'b1;
                end else if (mem_valid && inflight_q) begin
                    if (buf_count_q == BUF_FULL) begin
                        err_d[1] = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                if (inflight_q && !mem_valid) begin
                    err_d[2] = 1'b1;
                end

                if (push) begin
                    mem_d[wr_ptr_q] = mem_data;
                    wr_ptr_d        = ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end
                if (push && !pop) begin
                    buf_count_d = buf_count_q + 1'b1;
                end else if (!push && pop) begin
                    buf_count_d = buf_count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q       <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            buf_count_q <= '0;
            err_q       <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            buf_count_q <= buf_count_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end

endmodule

// File: tb/tb_mem_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_mem_fifo_drain
// Drives mem_fifo_drain with directed scenarios and randomized traffic while
// modelling memory_core as a queue of written words. A queue-based reference
// of the drain (core occupancy, local buffer, sticky flags) predicts every
// output each cycle.
// ---------------------------------------------------------------------------
module tb_mem_fifo_drain;

    localparam int unsigned DW = 16;
    localparam int unsigned OW = 16;
    localparam int unsigned BD = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_en = 1'b0;
    logic          flush = 1'b0;
    logic [OW-1:0] depth = 16'd4;
    logic          wen_mon = 1'b0;
    logic          mem_ren;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [OW-1:0] occupancy;
    logic          empty;
    logic          full;
    logic [2:0]    err_flags;

    mem_fifo_drain #(.DATA_WIDTH(DW), .OCC_WIDTH(OW), .BUF_DEPTH(BD)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .flush     (flush),
        .depth     (depth),
        .wen_mon   (wen_mon),
        .mem_ren   (mem_ren),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .empty     (empty),
        .full      (full),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference state
    int unsigned   depth_m;
    logic [DW-1:0] core_q[$];
    logic [DW-1:0] buf_m[$];
    bit            inflight_m;
    bit [2:0]      err_m;
    bit            pend_v;
    logic [DW-1:0] pend_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        core_q.delete();
        buf_m.delete();
        inflight_m = 1'b0;
        err_m      = '0;
        pend_v     = 1'b0;
        pend_d     = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".mem_ren"},   {31'd0, mem_ren},   32'd0);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".out_data"},  {16'd0, out_data},  32'd0);
        check({tag, ".occupancy"}, {16'd0, occupancy}, 32'd0);
        check({tag, ".empty"},     {31'd0, empty},     32'd1);
        check({tag, ".full"},      {31'd0, full},      32'd0);
        check({tag, ".err_flags"}, {29'd0, err_flags}, 32'd0);
    endtask

    task automatic do_reset(input int unsigned d);
        reset     = 1'b1;
        clk_en    = 1'b0;
        flush     = 1'b0;
        wen_mon   = 1'b0;
        mem_valid = 1'b0;
        out_ready = 1'b0;
        depth     = OW'(d);
        depth_m   = d;
        clear_model();
        #2;
        check_reset_values("reset");
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, check predicted outputs, advance model.
    task automatic step(input bit ce, input bit fl, input bit wen, input bit rdy,
                        input logic [DW-1:0] wd, input bit inj, input bit sup);
        bit            mv, ren_e, pop_e, full_e, was_infl;
        int unsigned   bsz;
        logic [DW-1:0] md;
        clk_en    = ce;
        flush     = fl;
        wen_mon   = wen;
        out_ready = rdy;
        mv        = (pend_v && !sup) || inj;
        md        = pend_v ? pend_d : DW'($urandom);
        mem_valid = mv;
        mem_data  = md;
        #1;
        bsz    = buf_m.size();
        full_e = (core_q.size() == depth_m);
        pop_e  = ce && (bsz > 0) && rdy;
        ren_e  = ce && !fl && (core_q.size() > 0) &&
                 ((bsz + int'(inflight_m) - int'(pop_e)) < BD);
        check("mem_ren",   {31'd0, mem_ren},   {31'd0, ren_e});
        check("out_valid", {31'd0, out_valid}, {31'd0, bsz > 0});
        if (bsz > 0) check("out_data", {16'd0, out_data}, {16'd0, buf_m[0]});
        check("occupancy", {16'd0, occupancy}, core_q.size());
        check("empty",     {31'd0, empty},     {31'd0, core_q.size() == 0});
        check("full",      {31'd0, full},      {31'd0, full_e});
        check("err_flags", {29'd0, err_flags}, {29'd0, err_m});
        @(posedge clk);
        if (ce) begin
            if (fl) begin
                clear_model();
            end else begin
                was_infl = inflight_m;
                if (pop_e) void'(buf_m.pop_front());
                if (mv && was_infl) begin
                    if (bsz == BD) err_m[1] = 1'b1;
                    else buf_m.push_back(md);
                end
                if (mv && !was_infl) err_m[1] = 1'b1;
                if (was_infl && !mv) err_m[2] = 1'b1;
                if (wen && full_e && !ren_e) begin
                    err_m[0] = 1'b1;
                end else begin
                    if (ren_e) pend_d = core_q.pop_front();
                    if (wen) core_q.push_back(wd);
                end
                pend_v     = ren_e;
                inflight_m = ren_e;
            end
        end
        #1;
    endtask

    task automatic idle(input int unsigned n, input bit rdy);
        for (int unsigned i = 0; i < n; i++) step(1, 0, 0, rdy, '0, 0, 0);
    endtask

    initial begin
        // Single word through an idle block
        do_reset(4);
        step(1, 0, 1, 1, 16'h00A5, 0, 0);
        idle(6, 1);

        // Streaming, 8 back-to-back writes
        do_reset(8);
        for (int unsigned i = 0; i < 8; i++) step(1, 0, 1, 1, DW'(16'h0100 + i), 0, 0);
        idle(8, 1);

        // Backpressure: buffer fills, reads stop, then drain in order
        do_reset(8);
        for (int unsigned i = 0; i < 4; i++) step(1, 0, 1, 0, DW'(16'h0200 + i), 0, 0);
        idle(10, 0);
        check("bp.occupancy", {16'd0, occupancy}, 32'd2);
        check("bp.head", {16'd0, out_data}, 32'h0200);
        idle(10, 1);

        // Overflow on a full core, sticky until flush
        do_reset(2);
        for (int unsigned i = 0; i < 6; i++) step(1, 0, 1, 0, DW'(16'h0300 + i), 0, 0);
        check("ovf.flag", {31'd0, err_flags[0]}, 32'd1);
        check("ovf.occupancy", {16'd0, occupancy}, 32'd2);
        idle(4, 0);
        check("ovf.sticky", {31'd0, err_flags[0]}, 32'd1);
        step(1, 1, 0, 0, '0, 0, 0);
        idle(2, 0);

        // Spurious valid, then missing valid
        do_reset(4);
        step(1, 0, 0, 0, '0, 1, 0);
        check("spur.flag", {29'd0, err_flags}, 32'b010);
        check("spur.out_valid", {31'd0, out_valid}, 32'd0);
        step(1, 0, 1, 1, 16'h0400, 0, 0);
        for (int unsigned i = 0; i < 4; i++) step(1, 0, 0, 1, '0, 0, 1);
        check("miss.flag", {29'd0, err_flags}, 32'b110);

        // clk_en gaps mid-stream, then flush with words buffered
        do_reset(8);
        for (int unsigned i = 0; i < 3; i++) step(1, 0, 1, 1, DW'(16'h0500 + i), 0, 0);
        for (int unsigned i = 0; i < 3; i++) step(0, 0, 1, 1, 16'hDEAD, 1, 0);
        idle(2, 1);
        for (int unsigned i = 0; i < 5; i++) step(1, 0, 1, 0, DW'(16'h0600 + i), 0, 0);
        step(1, 1, 0, 0, '0, 0, 0);
        check("flush.out_valid", {31'd0, out_valid}, 32'd0);
        check("flush.occupancy", {16'd0, occupancy}, 32'd0);
        idle(3, 1);

        // Randomized traffic over several depths
        for (int unsigned r = 0; r < 4; r++) begin
            do_reset($urandom_range(1, 6));
            for (int unsigned i = 0; i < 400; i++) begin
                step(($urandom % 8) != 0, ($urandom % 60) == 0, $urandom % 2,
                     ($urandom % 3) != 0, DW'($urandom),
                     ($urandom % 80) == 0, ($urandom % 80) == 0);
            end
        end

        // Asynchronous reset mid-stream
        do_reset(8);
        for (int unsigned i = 0; i < 5; i++) step(1, 0, 1, 1, DW'(16'h0700 + i), 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        do_reset(8);
        idle(3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
